// File: rtl/border_fx_ctrl.sv
// Border effect controller: frame-synchronous mode/colour shadow registers
// for an OLED border overlay (OFF / STATIC / BLINK / CYCLE).
module border_fx_ctrl #(
    parameter int FRAME_LAST = 6143,
    parameter int FX_FRAMES  = 15
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [12:0] pixel_index,
    input  logic        SW_12,
    input  logic        SW_11,
    input  logic        mode_btn,
    output logic [15:0] border_color,
    output logic [1:0]  border_width,
    output logic [1:0]  mode,
    output logic        frame_start
);

    typedef enum logic [1:0] {
        M_OFF    = 2'd0,
        M_STATIC = 2'd1,
        M_BLINK  = 2'd2,
        M_CYCLE  = 2'd3
    } mode_e;

    localparam logic [12:0] IDX_LAST = 13'(FRAME_LAST);
    localparam logic [7:0]  FX_LAST  = 8'(FX_FRAMES - 1);

    mode_e       mode_q, mode_d;
    logic [12:0] idx_prev_q, idx_prev_d;
    logic        fs_q, fs_d;
    logic        pend_q, pend_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic [1:0]  pal_q, pal_d;
    logic [15:0] color_q, color_d;
    logic [1:0]  width_q, width_d;

    logic        advance;
    logic        wrap;
    logic [15:0] base;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q     <= M_OFF;
            idx_prev_q <= 13'h1FFF;
            fs_q       <= 1'b0;
            pend_q     <= 1'b0;
            cnt_q      <= 8'd0;
            phase_q    <= 1'b0;
            pal_q      <= 2'd0;
            color_q    <= 16'h0000;
            width_q    <= 2'd0;
        end else begin
            mode_q     <= mode_d;
            idx_prev_q <= idx_prev_d;
            fs_q       <= fs_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            pal_q      <= pal_d;
            color_q    <= color_d;
            width_q    <= width_d;
        end
    end

    // Out-of-range scan indices are ignored so they cannot fake a boundary.
    always_comb begin
        idx_prev_d = idx_prev_q;
        if (pixel_index <= IDX_LAST) idx_prev_d = pixel_index;
        fs_d    = (pixel_index == 13'd0) && (idx_prev_q != 13'd0);
        advance = fs_q && (pend_q || mode_btn);
        wrap    = (cnt_q == FX_LAST);
        pend_d  = fs_q ? 1'b0 : (pend_q || mode_btn);
        mode_d  = mode_q;
        if (advance) begin
            unique case (mode_q)
                M_OFF:    mode_d = M_STATIC;
                M_STATIC: mode_d = M_BLINK;
                M_BLINK:  mode_d = M_CYCLE;
                M_CYCLE:  mode_d = M_OFF;
            endcase
        end
    end

    // A mode change overrides any step tick landing on the same frame.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        pal_d   = pal_q;
        if (advance) begin
            cnt_d   = 8'd0;
            phase_d = 1'b0;
            pal_d   = 2'd0;
        end else if (fs_q) begin
            cnt_d = wrap ? 8'd0 : cnt_q + 8'd1;
            if (wrap) begin
                phase_d = ~phase_q;
                pal_d   = pal_q + 2'd1;
            end
        end
    end

    always_comb begin
        if (SW_12)      base = 16'hF800;
        else if (SW_11) base = 16'h001F;
        else            base = 16'hFFFF;
        color_d = color_q;
        width_d = width_q;
        if (fs_q) begin
            width_d = 2'd3;
            unique case (mode_d)
                M_OFF: begin
                    color_d = 16'h0000;
                    width_d = 2'd0;
                end
                M_STATIC: color_d = base;
                M_BLINK:  color_d = phase_d ? 16'h0000 : base;
                M_CYCLE: begin
                    unique case (pal_d)
                        2'd0: color_d = 16'hF800;
                        2'd1: color_d = 16'h07E0;
                        2'd2: color_d = 16'h001F;
                        2'd3: color_d = 16'hFFFF;
                    endcase
                end
            endcase
        end
    end

    assign border_color = color_q;
    assign border_width = width_q;
    assign mode         = mode_q;
    assign frame_start  = fs_q;

endmodule
